avl_burst_scheduler: RTL and testbench
======================================

AVL_BURST_SCHEDULER -- requirements
Module: avl_burst_scheduler

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, Avalon beats per burst (1..64).
REQ-002 SHALL have parameter ADDR_LIMIT, default 25'h1000000, wrap point for both address pointers; a multiple of BURST_LEN.
REQ-003 SHALL have parameter OB_DEPTH, default 256, output FIFO capacity in 128-bit words.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- calib_done  in  1  memory calibration complete
- writes_en  in  1  write path enable
- reads_en  in  1  read path enable
- ib_re  out  1  input FIFO pop; show-ahead FIFO
- ib_data  in  128  input FIFO head word
- ib_count  in  9  input FIFO read-side fill
- ob_we  out  1  output FIFO push
- ob_data  out  128  output FIFO word
- ob_count  in  9  output FIFO write-side fill
- avl_ready  in  1  controller ready (inverse waitrequest)
- avl_burstbegin  out  1  first-beat/command marker
- avl_address  out  25  burst word address
- avl_size  out  8  burst count, constant BURST_LEN
- avl_read_req  out  1  read command
- avl_rdata_valid  in  1  read beat valid
- avl_rdata  in  128  read beat
- avl_write_req  out  1  write beat request
- avl_wdata  out  128  write beat
- avl_be  out  16  byte enables, constant all-ones
- busy  out  1  high in any state other than IDLE
- stray_rdata  out  1  sticky; rdata_valid seen outside RD_WAIT

Function
REQ-005 SHALL implement states IDLE, WR_BURST, RD_CMD, RD_WAIT.
REQ-006 Write eligible: calib_done & writes_en & ib_count >= BURST_LEN & !ib_empty-equivalent (ib_count nonzero).
REQ-007 Read eligible: calib_done & reads_en & ob_count <= OB_DEPTH-BURST_LEN.
REQ-008 In IDLE, one eligible -> grant it; both eligible -> grant the opposite of last_grant; neither -> stay IDLE. Grant takes effect on the next cycle.
REQ-009 last_grant SHALL update on each grant; its reset value is READ, so the first contested grant goes to WRITE.
REQ-010 WR_BURST: avl_write_req=1, avl_address=wr_addr, avl_wdata=ib_data (combinational). ib_re = avl_write_req & avl_ready.
REQ-011 avl_burstbegin SHALL be high from the first WR_BURST cycle until its first beat is accepted, and low otherwise.
REQ-012 After the BURST_LEN-th accepted beat: wr_addr += BURST_LEN, wrapping to 0 at ADDR_LIMIT; go to IDLE in the same cycle.
REQ-013 RD_CMD: avl_read_req=1, avl_burstbegin=1, avl_address=rd_addr, held until avl_ready; then rd_addr += BURST_LEN (same wrap), go to RD_WAIT.
REQ-014 RD_WAIT: each avl_rdata_valid beat -> ob_we=1, ob_data=avl_rdata, both registered with 1-cycle latency; after BURST_LEN beats -> IDLE.
REQ-015 Loss of enable or calib_done mid-burst SHALL NOT abort the burst; it completes, then eligibility is re-evaluated.
REQ-016 avl_rdata_valid outside RD_WAIT SHALL be dropped (no ob_we) and SHALL set stray_rdata.
REQ-017 Outside active states, avl_read_req, avl_write_req, avl_burstbegin and ib_re SHALL be 0; avl_size=BURST_LEN and avl_be=16'hFFFF always.

Reset
REQ-018 reset_n low SHALL immediately force: state IDLE, wr_addr=rd_addr=0, beat counters 0, last_grant=READ, all request/strobe outputs 0, ob_data=0, avl_address=0, stray_rdata=0, busy=0; stats counters 0 when present.
REQ-019 Reset mid-burst SHALL abandon the burst; release SHALL be followed by IDLE behaviour on the next clk edge.

Configuration
REQ-020 With macro AVL_BURST_SCHEDULER_STATS_EN defined: add outputs wr_bursts (out, 16) and rd_bursts (out, 16), each incremented (mod 2^16) on completion of its burst type. Without the macro the ports and logic SHALL be absent; all other behaviour is identical.

Verification
REQ-021 calib_done=0, writes_en=1, ib_count=100 -> no avl_write_req for 50 cycles; raise calib_done -> WR_BURST within 2 cycles, address 0.
REQ-022 BURST_LEN=4, avl_ready toggling 1010... -> exactly 4 ib_re pulses, burstbegin only until first acceptance, wr_addr becomes 4.
REQ-023 Both paths eligible continuously -> grants alternate W,R,W,R; addresses 0,0,4,4,8,8.
REQ-024 wr_addr=ADDR_LIMIT-4 and one write burst -> next write burst address 0.
REQ-025 ob_count=OB_DEPTH-BURST_LEN+1 -> no read; pulse avl_rdata_valid in IDLE -> no ob_we, stray_rdata=1.
REQ-026 reset_n asserted after 2 of 4 write beats -> all outputs at reset values immediately; after release, first write address 0.

Source files
------------

// File: rtl/avl_burst_scheduler.sv
// avl_burst_scheduler
// Moves BURST_LEN-beat bursts between a show-ahead input FIFO and an Avalon
// memory controller (writes), and from the controller into an output FIFO
// (reads). The arbiter alternates when both directions are eligible.
// Optional build macro: AVL_BURST_SCHEDULER_STATS_EN adds the wr_bursts and
// rd_bursts completion counters.
module avl_burst_scheduler #(
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned ADDR_LIMIT = 25'h1000000,
    parameter int unsigned OB_DEPTH   = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         calib_done,
    input  logic         writes_en,
    input  logic         reads_en,
    output logic         ib_re,
    input  logic [127:0] ib_data,
    input  logic [8:0]   ib_count,
    output logic         ob_we,
    output logic [127:0] ob_data,
    input  logic [8:0]   ob_count,
    input  logic         avl_ready,
    output logic         avl_burstbegin,
    output logic [24:0]  avl_address,
    output logic [7:0]   avl_size,
    output logic         avl_read_req,
    input  logic         avl_rdata_valid,
    input  logic [127:0] avl_rdata,
    output logic         avl_write_req,
    output logic [127:0] avl_wdata,
    output logic [15:0]  avl_be,
    output logic         busy,
    output logic         stray_rdata
`ifdef AVL_BURST_SCHEDULER_STATS_EN
    ,
    output logic [15:0]  wr_bursts,
    output logic [15:0]  rd_bursts
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_CMD   = 2'd2,
        RD_WAIT  = 2'd3
    } state_t;

    localparam logic        GRANT_WR  = 1'b0;
    localparam logic        GRANT_RD  = 1'b1;
    localparam logic [6:0]  BEAT_LAST = 7'(BURST_LEN - 1);
    localparam logic [24:0] ADDR_STEP = 25'(BURST_LEN);
    localparam logic [24:0] ADDR_WRAP = 25'(ADDR_LIMIT);
    localparam logic [9:0]  WR_NEED   = 10'(BURST_LEN);
    localparam logic [9:0]  RD_ROOM   = 10'(OB_DEPTH - BURST_LEN);

    state_t      state;
    logic [24:0] wr_addr;
    logic [24:0] rd_addr;
    logic [6:0]  wr_beat;
    logic [6:0]  rd_beat;
    logic        last_grant;
    logic        wr_elig;
    logic        rd_elig;
    logic        grant_wr;
    logic        grant_rd;
    logic        wr_done;
    logic        rd_done;

    // Both pointers advance by one burst and wrap to zero at ADDR_LIMIT.
    function automatic logic [24:0] addr_next(input logic [24:0] a);
        logic [24:0] n;
        n = a + ADDR_STEP;
        return (n == ADDR_WRAP) ? 25'd0 : n;
    endfunction

    assign avl_size  = 8'(BURST_LEN);
    assign avl_be    = 16'hFFFF;
    assign avl_wdata = ib_data;
    assign ib_re     = avl_write_req & avl_ready;

    assign wr_elig = calib_done & writes_en & ({1'b0, ib_count} >= WR_NEED) & (ib_count != 9'd0);
    assign rd_elig = calib_done & reads_en & ({1'b0, ob_count} <= RD_ROOM);

    assign wr_done = (state == WR_BURST) & avl_ready & (wr_beat == BEAT_LAST);
    assign rd_done = (state == RD_WAIT) & avl_rdata_valid & (rd_beat == BEAT_LAST);

    // Arbiter: a lone eligible path wins; a contest goes against last_grant.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (wr_elig && rd_elig) begin
            grant_wr = (last_grant == GRANT_RD);
            grant_rd = (last_grant == GRANT_WR);
        end else begin
            grant_wr = wr_elig;
            grant_rd = rd_elig;
        end
    end

    // Burst sequencer with registered Avalon command outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            wr_addr        <= 25'd0;
            rd_addr        <= 25'd0;
            wr_beat        <= 7'd0;
            rd_beat        <= 7'd0;
            last_grant     <= GRANT_RD;
            avl_write_req  <= 1'b0;
            avl_read_req   <= 1'b0;
            avl_burstbegin <= 1'b0;
            avl_address    <= 25'd0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        state          <= WR_BURST;
                        last_grant     <= GRANT_WR;
                        wr_beat        <= 7'd0;
                        avl_write_req  <= 1'b1;
                        avl_burstbegin <= 1'b1;
                        avl_address    <= wr_addr;
                        busy           <= 1'b1;
                    end else if (grant_rd) begin
                        state          <= RD_CMD;
                        last_grant     <= GRANT_RD;
                        rd_beat        <= 7'd0;
                        avl_read_req   <= 1'b1;
                        avl_burstbegin <= 1'b1;
                        avl_address    <= rd_addr;
                        busy           <= 1'b1;
                    end
                end
                WR_BURST: begin
                    if (avl_ready) begin
                        // burstbegin marks only the first beat of the burst
                        avl_burstbegin <= 1'b0;
                        if (wr_done) begin
                            state         <= IDLE;
                            wr_beat       <= 7'd0;
                            wr_addr       <= addr_next(wr_addr);
                            avl_write_req <= 1'b0;
                            avl_address   <= 25'd0;
                            busy          <= 1'b0;
                        end else begin
                            wr_beat <= wr_beat + 7'd1;
                        end
                    end
                end
                RD_CMD: begin
                    if (avl_ready) begin
                        state          <= RD_WAIT;
                        rd_addr        <= addr_next(rd_addr);
                        avl_read_req   <= 1'b0;
                        avl_burstbegin <= 1'b0;
                        avl_address    <= 25'd0;
                    end
                end
                RD_WAIT: begin
                    if (avl_rdata_valid) begin
                        if (rd_done) begin
                            state   <= IDLE;
                            rd_beat <= 7'd0;
                            busy    <= 1'b0;
                        end else begin
                            rd_beat <= rd_beat + 7'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read beats land in the output FIFO one cycle later; strays are dropped and flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ob_we       <= 1'b0;
            ob_data     <= 128'd0;
            stray_rdata <= 1'b0;
        end else begin
            ob_we <= (state == RD_WAIT) & avl_rdata_valid;
            if ((state == RD_WAIT) && avl_rdata_valid) begin
                ob_data <= avl_rdata;
            end
            if ((state != RD_WAIT) && avl_rdata_valid) begin
                stray_rdata <= 1'b1;
            end
        end
    end

`ifdef AVL_BURST_SCHEDULER_STATS_EN
    // Completed-burst counters, free-running modulo 2^16.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bursts <= 16'd0;
            rd_bursts <= 16'd0;
        end else begin
            if (wr_done) begin
                wr_bursts <= wr_bursts + 16'd1;
            end
            if (rd_done) begin
                rd_bursts <= rd_bursts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_avl_burst_scheduler.sv
// Testbench for avl_burst_scheduler: directed stimulus, expected Avalon and
// output-FIFO traffic queued up front and checked by an independent monitor.
module tb_avl_burst_scheduler;

    localparam int BL  = 4;
    localparam int AL  = 16;
    localparam int OBD = 256;

    typedef struct packed {
        logic [24:0]  addr;
        logic [127:0] data;
        logic         bb;
    } wexp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         calib_done = 1'b0;
    logic         writes_en = 1'b0;
    logic         reads_en = 1'b0;
    logic         ib_re;
    logic [127:0] ib_data;
    logic [8:0]   ib_count = 9'd100;
    logic         ob_we;
    logic [127:0] ob_data;
    logic [8:0]   ob_count = 9'd0;
    logic         avl_ready = 1'b0;
    logic         avl_burstbegin;
    logic [24:0]  avl_address;
    logic [7:0]   avl_size;
    logic         avl_read_req;
    logic         avl_rdata_valid;
    logic [127:0] avl_rdata;
    logic         avl_write_req;
    logic [127:0] avl_wdata;
    logic [15:0]  avl_be;
    logic         busy;
    logic         stray_rdata;
`ifdef AVL_BURST_SCHEDULER_STATS_EN
    logic [15:0]  wr_bursts;
    logic [15:0]  rd_bursts;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    wexp_t        qW[$];
    logic [24:0]  qR[$];
    logic [127:0] qO[$];
    int ib_re_cnt = 0;
    int ob_we_cnt = 0;
    logic [31:0] gl = 32'd0;
    int ib_seq = 0;
    int wseq = 0;
    int stray_reqs = 0;
    int i, cnt, snap;

    int pend = 0;
    int bi = 0;
    logic [24:0] base = 25'd0;
    int stray_done = 0;
    bit fire_w = 1'b0;

    avl_burst_scheduler #(.BURST_LEN(BL), .ADDR_LIMIT(AL), .OB_DEPTH(OBD)) dut (
        .clk(clk), .reset_n(reset_n), .calib_done(calib_done),
        .writes_en(writes_en), .reads_en(reads_en),
        .ib_re(ib_re), .ib_data(ib_data), .ib_count(ib_count),
        .ob_we(ob_we), .ob_data(ob_data), .ob_count(ob_count),
        .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin),
        .avl_address(avl_address), .avl_size(avl_size),
        .avl_read_req(avl_read_req), .avl_rdata_valid(avl_rdata_valid),
        .avl_rdata(avl_rdata), .avl_write_req(avl_write_req),
        .avl_wdata(avl_wdata), .avl_be(avl_be), .busy(busy),
        .stray_rdata(stray_rdata)
`ifdef AVL_BURST_SCHEDULER_STATS_EN
        , .wr_bursts(wr_bursts), .rd_bursts(rd_bursts)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pat_w(input int s);
        return {32'hC0DE_0000, 32'(s), ~32'(s), 32'h1234_5678};
    endfunction

    function automatic logic [127:0] pat_r(input logic [24:0] a, input int b);
        return {32'h5EAD_0000, 7'd0, a, 32'(b), 32'hA5A5_5A5A};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm, input string why);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", nm, why);
    endtask

    task automatic push_wr(input logic [24:0] a, input int beats);
        for (int b = 0; b < beats; b++) begin
            qW.push_back('{addr: a, data: pat_w(wseq), bb: 1'(b == 0)});
            wseq++;
        end
    endtask

    task automatic push_rd(input logic [24:0] a);
        qR.push_back(a);
        for (int b = 0; b < BL; b++) qO.push_back(pat_r(a, b));
    endtask

    task automatic wait_idle(input int max, input bit toggle);
        int k;
        k = 0;
        while (busy && k < max) begin
            if (toggle) avl_ready = ~avl_ready;
            @(posedge clk); #1;
            k++;
        end
        if (busy) bad("busy_drop", "timed out waiting for IDLE");
        avl_ready = 1'b1;
    endtask

    task automatic run_burst(input bit wr, input bit toggle);
        int k;
        k = 0;
        if (wr) writes_en = 1'b1; else reads_en = 1'b1;
        while (!(wr ? avl_write_req : avl_read_req) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        writes_en = 1'b0;
        reads_en  = 1'b0;
        if (!(wr ? avl_write_req : avl_read_req)) bad(wr ? "wr_grant" : "rd_grant", "timed out waiting for request");
        wait_idle(100, toggle);
    endtask

    // Environment: show-ahead input FIFO head and read-data responder.
    initial begin
        avl_rdata_valid = 1'b0;
        avl_rdata = 128'd0;
        ib_data = pat_w(0);
        forever begin
            @(negedge clk);
            fire_w = reset_n && ib_re;
            if (reset_n && avl_read_req && avl_ready) begin
                pend = BL;
                bi = 0;
                base = avl_address;
            end
            @(posedge clk); #1;
            if (fire_w) begin
                ib_seq++;
                ib_data = pat_w(ib_seq);
            end
            avl_rdata_valid = 1'b0;
            if (stray_done < stray_reqs) begin
                stray_done++;
                avl_rdata_valid = 1'b1;
                avl_rdata = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
            end else if (pend > 0) begin
                avl_rdata_valid = 1'b1;
                avl_rdata = pat_r(base, bi);
                bi++;
                pend--;
            end
        end
    end

    // Monitor: pops the expected queues whenever the DUT presents traffic.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (ib_re) ib_re_cnt++;
                if (avl_write_req) begin
                    if (qW.size() == 0) begin
                        bad("wr_unexpected", "write request with nothing expected");
                    end else begin
                        chk("wr_burstbegin", 128'(avl_burstbegin), 128'(qW[0].bb));
                        chk("wr_address", 128'(avl_address), 128'(qW[0].addr));
                        chk("wr_ib_re", 128'(ib_re), 128'(avl_ready));
                        if (avl_ready) begin
                            chk("wr_wdata", avl_wdata, qW[0].data);
                            if (qW[0].bb) gl = {gl[30:0], 1'b0};
                            void'(qW.pop_front());
                        end
                    end
                end else if (ib_re) begin
                    bad("ib_re_idle", "ib_re without write request");
                end
                if (avl_read_req) begin
                    if (qR.size() == 0) begin
                        bad("rd_unexpected", "read command with nothing expected");
                    end else begin
                        chk("rd_address", 128'(avl_address), 128'(qR[0]));
                        chk("rd_burstbegin", 128'(avl_burstbegin), 128'(1'b1));
                        if (avl_ready) begin
                            gl = {gl[30:0], 1'b1};
                            void'(qR.pop_front());
                        end
                    end
                end
                if (!avl_write_req && !avl_read_req && avl_burstbegin)
                    bad("bb_idle", "burstbegin with no request");
                if (ob_we) begin
                    ob_we_cnt++;
                    if (qO.size() == 0) begin
                        bad("ob_unexpected", "ob_we with nothing expected");
                    end else begin
                        chk("ob_data", ob_data, qO[0]);
                        void'(qO.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_write_req", 128'(avl_write_req), 128'(1'b0));
        chk("rst_read_req", 128'(avl_read_req), 128'(1'b0));
        chk("rst_burstbegin", 128'(avl_burstbegin), 128'(1'b0));
        chk("rst_ib_re", 128'(ib_re), 128'(1'b0));
        chk("rst_ob_we", 128'(ob_we), 128'(1'b0));
        chk("rst_ob_data", ob_data, 128'd0);
        chk("rst_address", 128'(avl_address), 128'd0);
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_stray", 128'(stray_rdata), 128'(1'b0));
        chk("avl_size", 128'(avl_size), 128'(BL));
        chk("avl_be", 128'(avl_be), 128'hFFFF);
        reset_n = 1'b1;
        avl_ready = 1'b1;
        @(posedge clk); #1;

        // No calibration: a fully eligible write path must stay quiet.
        push_wr(25'd0, BL);
        writes_en = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (avl_write_req) cnt++;
        end
        chk("nocal_write_cycles", 128'(cnt), 128'd0);
        calib_done = 1'b1;
        i = 0;
        while (!avl_write_req && i < 4) begin
            @(posedge clk); #1;
            i++;
        end
        chk("cal_to_write_le2", 128'(avl_write_req && i <= 2), 128'(1'b1));
        writes_en = 1'b0;
        wait_idle(40, 1'b0);

        // Write burst with avl_ready alternating.
        snap = ib_re_cnt;
        push_wr(25'd4, BL);
        run_burst(1'b1, 1'b1);
        chk("ib_re_pulses", 128'(ib_re_cnt - snap), 128'(BL));

        // Fresh reset, then both paths contend continuously.
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        push_wr(25'd0, BL); push_rd(25'd0);
        push_wr(25'd4, BL); push_rd(25'd4);
        push_wr(25'd8, BL); push_rd(25'd8);
        writes_en = 1'b1;
        reads_en = 1'b1;
        i = 0;
        while (qR.size() != 0 && i < 300) begin
            @(posedge clk); #1;
            i++;
        end
        writes_en = 1'b0;
        reads_en = 1'b0;
        if (qR.size() != 0) bad("contend_reads", "timed out waiting for third read");
        wait_idle(100, 1'b0);
        chk("grant_order", 128'(gl[5:0]), 128'(6'b010101));

        // Pointer wrap at ADDR_LIMIT for both directions.
        push_wr(25'd12, BL);
        run_burst(1'b1, 1'b0);
        push_wr(25'd0, BL);
        run_burst(1'b1, 1'b0);
        push_rd(25'd12);
        run_burst(1'b0, 1'b0);

        // Output FIFO one word too full: no read; stray beat dropped.
        ob_count = 9'(OBD - BL + 1);
        reads_en = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (avl_read_req || busy) cnt++;
        end
        chk("full_ob_no_read", 128'(cnt), 128'd0);
        reads_en = 1'b0;
        snap = ob_we_cnt;
        stray_reqs++;
        repeat (4) @(posedge clk);
        #1;
        chk("stray_flag", 128'(stray_rdata), 128'(1'b1));
        chk("stray_no_ob_we", 128'(ob_we_cnt - snap), 128'd0);
        ob_count = 9'(OBD - BL);
        push_rd(25'd0);
        run_burst(1'b0, 1'b0);

        // Reset after two of four write beats.
        push_wr(25'd4, 2);
        avl_ready = 1'b1;
        writes_en = 1'b1;
        i = 0;
        while (!avl_write_req && i < 20) begin
            @(posedge clk); #1;
            i++;
        end
        writes_en = 1'b0;
        if (!avl_write_req) bad("abort_grant", "timed out waiting for request");
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 reset_n = 1'b0;
        #1;
        chk("abort_write_req", 128'(avl_write_req), 128'(1'b0));
        chk("abort_burstbegin", 128'(avl_burstbegin), 128'(1'b0));
        chk("abort_ib_re", 128'(ib_re), 128'(1'b0));
        chk("abort_address", 128'(avl_address), 128'd0);
        chk("abort_busy", 128'(busy), 128'(1'b0));
        chk("abort_ob_we", 128'(ob_we), 128'(1'b0));
        chk("abort_ob_data", ob_data, 128'd0);
        chk("abort_stray", 128'(stray_rdata), 128'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        push_wr(25'd0, BL);
        run_burst(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        chk("left_writes", 128'(qW.size()), 128'd0);
        chk("left_reads", 128'(qR.size()), 128'd0);
        chk("left_ob_words", 128'(qO.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
